// File: rtl/vproc_pkg.sv
// Shared types and helpers for the vector MUL/DIV unit divider path.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package vproc_pkg;

   typedef enum logic [1:0] {
      DIV_DIV  = 2'b00,
      DIV_DIVU = 2'b01,
      DIV_REM  = 2'b10,
      DIV_REMU = 2'b11
   } div_op_e;

   typedef enum logic [2:0] {
      DIV_IDLE,
      DIV_CLZ,
      DIV_SHIFT,
      DIV_DIVIDE,
      DIV_FINISH
   } div_state_e;

   localparam logic [31:0] DIV_INT_MIN = 32'h8000_0000;
   localparam logic [31:0] DIV_ALL_ONE = 32'hFFFF_FFFF;

   // Even encodings (DIV, REM) are the signed flavours.
   function automatic logic div_op_signed(input div_op_e op);
      return ~op[0];
   endfunction

   // Upper encodings (REM, REMU) return the remainder.
   function automatic logic div_op_rem(input div_op_e op);
      return op[1];
   endfunction

   function automatic logic [31:0] bit_rev32(input logic [31:0] d);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) begin
         r[i] = d[31-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/vproc_div_shift_clz.sv
// Divider shift/CLZ helper: CLZ of the divisor and its left-normalisation.
// Latency: purely combinational, results valid in the same cycle as the enables.
// Backpressure: none; outputs are zero while the matching enable is low.
//
// Ports:
//   clz_en_i        CLZ request (controller CLZ state)
//   clz_data_rev_i  bit-reversed |divisor|
//   clz_result_o    leading zeros of |divisor| (32 when zero)
//   shift_en_i      shift request (controller SHIFT state)
//   shift_amt_i     left shift amount
//   operand_b_i     |divisor|
//   op_b_shifted_o  operand_b_i << shift_amt_i
module vproc_div_shift_clz (
   input  logic        clz_en_i,
   input  logic [31:0] clz_data_rev_i,
   output logic [5:0]  clz_result_o,
   input  logic        shift_en_i,
   input  logic [5:0]  shift_amt_i,
   input  logic [31:0] operand_b_i,
   output logic [31:0] op_b_shifted_o
);

   // Leading zeros of the divisor are the trailing zeros of its reversal,
   // so the lowest set bit of the reversed word wins.
   always_comb begin
      clz_result_o = 6'd32;
      for (int i = 31; i >= 0; i--) begin
         if (clz_data_rev_i[i]) begin
            clz_result_o = 6'(i);
         end
      end
      if (!clz_en_i) begin
         clz_result_o = '0;
      end
   end

   assign op_b_shifted_o = shift_en_i ? (operand_b_i << shift_amt_i) : '0;

endmodule

// File: rtl/vproc_div_seq_ctrl.sv
// Iterative 32-bit DIV/DIVU/REM/REMU controller driving the shared shift/CLZ block.
// Latency: accept edge to out_valid_o is clz(|b|)+3 edges; divide-by-zero/overflow reach FINISH on the CLZ edge.
// Backpressure: in_ready_o only in IDLE; result and id held in FINISH until out_ready_i.
//
// Ports:
//   clk_i, sync_rst_i          clock, synchronous active-high reset
//   in_valid_i/in_ready_o      request handshake; in_op_i, in_op_a_i, in_op_b_i, in_id_i payload
//   kill_i                     flush of the in-flight op (ignored in IDLE)
//   out_valid_o/out_ready_i    result handshake; out_result_o, out_id_o payload
//   busy_o                     any state other than IDLE
//   muldiv_operand_b_o         |divisor| to the shift/CLZ block
//   div_clz_en_o/_data_rev_o   CLZ request and bit-reversed |divisor|
//   div_clz_result_i           CLZ of |divisor|
//   div_shift_en_o/_amt_o      shift request and latched CLZ amount
//   div_op_b_shifted_i         normalised |divisor|
module vproc_div_seq_ctrl
   import vproc_pkg::*;
#(
   parameter int unsigned ID_W = 4
) (
   input  logic            clk_i,
   input  logic            sync_rst_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [1:0]      in_op_i,
   input  logic [31:0]     in_op_a_i,
   input  logic [31:0]     in_op_b_i,
   input  logic [ID_W-1:0] in_id_i,
   input  logic            kill_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [31:0]     out_result_o,
   output logic [ID_W-1:0] out_id_o,
   output logic            busy_o,
   output logic [31:0]     muldiv_operand_b_o,
   output logic            div_clz_en_o,
   output logic [31:0]     div_clz_data_rev_o,
   input  logic [5:0]      div_clz_result_i,
   output logic            div_shift_en_o,
   output logic [5:0]      div_shift_amt_o,
   input  logic [31:0]     div_op_b_shifted_i
);

   div_state_e      state_q, state_d;
   div_op_e         op_q;
   logic [ID_W-1:0] id_q;
   logic [31:0]     a_abs_q, b_abs_q;
   logic            a_neg_q, b_neg_q;
   logic [32:0]     rem_q;
   logic [31:0]     quot_q, div_q, result_q;
   logic [5:0]      cnt_q, amt_q;

   // Incoming operand magnitudes; abs only applies to the signed flavours.
   logic        in_signed, in_a_neg, in_b_neg;
   logic [31:0] in_a_abs, in_b_abs;
   assign in_signed = div_op_signed(div_op_e'(in_op_i));
   assign in_a_neg  = in_signed & in_op_a_i[31];
   assign in_b_neg  = in_signed & in_op_b_i[31];
   assign in_a_abs  = in_a_neg ? (32'd0 - in_op_a_i) : in_op_a_i;
   assign in_b_abs  = in_b_neg ? (32'd0 - in_op_b_i) : in_op_b_i;

   // Special cases decided in CLZ. |a| == INT_MIN only for a == 0x80000000
   // on a signed op, and |b| == 1 with b negative only for b == -1.
   logic        is_rem, b_zero, sgn_ovf;
   logic [31:0] a_raw;
   assign is_rem  = div_op_rem(op_q);
   assign b_zero  = (b_abs_q == 32'd0);
   assign sgn_ovf = div_op_signed(op_q) && a_neg_q && (a_abs_q == DIV_INT_MIN)
                    && b_neg_q && (b_abs_q == 32'd1);
   assign a_raw   = a_neg_q ? (32'd0 - a_abs_q) : a_abs_q;

   // One restoring step; 33-bit compare keeps the full 32-bit remainder range.
   logic [32:0] div_ext, rem_step;
   logic        rem_ge;
   logic [31:0] quot_step, quot_fix, rem_fix;
   assign div_ext   = {1'b0, div_q};
   assign rem_ge    = (rem_q >= div_ext);
   assign rem_step  = rem_ge ? (rem_q - div_ext) : rem_q;
   assign quot_step = {quot_q[30:0], rem_ge};
   assign quot_fix  = (a_neg_q ^ b_neg_q) ? (32'd0 - quot_step) : quot_step;
   assign rem_fix   = a_neg_q ? (32'd0 - rem_step[31:0]) : rem_step[31:0];

   always_ff @(posedge clk_i) begin
      if (sync_rst_i) begin
         state_q <= DIV_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      in_ready_o     = 1'b0;
      out_valid_o    = 1'b0;
      busy_o         = 1'b1;
      div_clz_en_o   = 1'b0;
      div_shift_en_o = 1'b0;
      unique case (state_q)
         DIV_IDLE: begin
            in_ready_o = 1'b1;
            busy_o     = 1'b0;
            if (in_valid_i) begin
               state_d = DIV_CLZ;
            end
         end
         DIV_CLZ: begin
            div_clz_en_o = 1'b1;
            state_d      = (b_zero || sgn_ovf) ? DIV_FINISH : DIV_SHIFT;
         end
         DIV_SHIFT: begin
            div_shift_en_o = 1'b1;
            state_d        = DIV_DIVIDE;
         end
         DIV_DIVIDE: begin
            if (cnt_q == 6'd0) begin
               state_d = DIV_FINISH;
            end
         end
         DIV_FINISH: begin
            out_valid_o = 1'b1;
            if (out_ready_i) begin
               state_d = DIV_IDLE;
            end
         end
         default: begin
            state_d = DIV_IDLE;
         end
      endcase
      // Flush beats any handshake, including a result being taken this cycle.
      if (kill_i && (state_q != DIV_IDLE)) begin
         state_d = DIV_IDLE;
      end
   end

   always_ff @(posedge clk_i) begin
      if (sync_rst_i) begin
         op_q     <= DIV_DIV;
         id_q     <= '0;
         a_abs_q  <= '0;
         b_abs_q  <= '0;
         a_neg_q  <= 1'b0;
         b_neg_q  <= 1'b0;
         rem_q    <= '0;
         quot_q   <= '0;
         div_q    <= '0;
         cnt_q    <= '0;
         amt_q    <= '0;
         result_q <= '0;
      end else begin
         unique case (state_q)
            DIV_IDLE: begin
               if (in_valid_i) begin
                  op_q    <= div_op_e'(in_op_i);
                  id_q    <= in_id_i;
                  a_abs_q <= in_a_abs;
                  b_abs_q <= in_b_abs;
                  a_neg_q <= in_a_neg;
                  b_neg_q <= in_b_neg;
               end
            end
            DIV_CLZ: begin
               amt_q <= div_clz_result_i;
               // Special results go out as-is, without sign correction.
               if (b_zero) begin
                  quot_q   <= DIV_ALL_ONE;
                  rem_q    <= {1'b0, a_raw};
                  result_q <= is_rem ? a_raw : DIV_ALL_ONE;
               end else if (sgn_ovf) begin
                  quot_q   <= DIV_INT_MIN;
                  rem_q    <= '0;
                  result_q <= is_rem ? 32'd0 : DIV_INT_MIN;
               end
            end
            DIV_SHIFT: begin
               div_q  <= div_op_b_shifted_i;
               cnt_q  <= amt_q;
               rem_q  <= {1'b0, a_abs_q};
               quot_q <= '0;
            end
            DIV_DIVIDE: begin
               rem_q  <= rem_step;
               quot_q <= quot_step;
               div_q  <= div_q >> 1;
               if (cnt_q == 6'd0) begin
                  result_q <= is_rem ? rem_fix : quot_fix;
               end else begin
                  cnt_q <= cnt_q - 6'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign out_result_o       = result_q;
   assign out_id_o           = id_q;
   assign muldiv_operand_b_o = b_abs_q;
   assign div_clz_data_rev_o = bit_rev32(b_abs_q);
   assign div_shift_amt_o    = amt_q;

endmodule
